// File: rtl/move_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : move_input_ctrl
//  Purpose  : N-channel button front end for the maze game. Synchronises and
//             debounces raw buttons, produces press / auto-repeat move events,
//             and serves them one at a time (fixed priority, index 0 first)
//             over a valid/ready handshake, counting coalesced events.
//  Revision : 1.0  initial release
// ============================================================================
module move_input_ctrl #(
  parameter int N_BTN        = 4,
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int DIR_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             repeat_en,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [DIR_W-1:0] move_dir,
  output logic [N_BTN-1:0] btn_state,
  output logic [7:0]       drop_cnt
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int HW  = $clog2(REPEAT_DELAY + 1);

  logic [N_BTN-1:0] w_event;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_drop;
  logic [N_BTN-1:0] w_pend_nxt;
  logic             w_any;
  logic             w_load;
  logic [DIR_W-1:0] w_idx;
  logic [15:0]      w_ndrop;
  logic [15:0]      w_sum;
  logic [7:0]       w_drop_nxt;
  logic             r_valid;
  logic [DIR_W-1:0] r_dir;
  logic [7:0]       r_drop;

  // Per-channel synchroniser, debouncer and auto-repeat timer
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]     r_sync;
    logic           r_state;
    logic [DBW-1:0] r_db_cnt;
    logic [HW-1:0]  r_hold;
    logic           w_diff;
    logic           w_flip;
    logic           w_state_nxt;
    logic           w_press;
    logic           w_rep;
    logic [HW-1:0]  w_hold_inc;

    // A level change is accepted on the edge the mismatch count reaches DB_CYCLES
    assign w_diff      = r_sync[1] != r_state;
    assign w_flip      = w_diff && (r_db_cnt == DBW'(DB_CYCLES - 1));
    assign w_state_nxt = w_flip ? r_sync[1] : r_state;
    assign w_press     = w_state_nxt && !r_state;
    assign w_hold_inc  = r_hold + HW'(1);
    // Repeats only while the button stays held across this edge, so none on release
    assign w_rep       = repeat_en && r_state && w_state_nxt &&
                         (w_hold_inc == HW'(REPEAT_DELAY));

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_sync <= 2'b00;
      else          r_sync <= {r_sync[0], btn_in[i]};
    end

    // Debounce: count consecutive mismatching samples, clear on match or accept
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_state  <= w_state_nxt;
        r_db_cnt <= (w_diff && !w_flip) ? r_db_cnt + DBW'(1) : '0;
      end
    end

    // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_RATE cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                                 r_hold <= '0;
      else if (!repeat_en || !w_state_nxt || w_press) r_hold <= '0;
      else if (w_rep)                               r_hold <= HW'(REPEAT_DELAY - REPEAT_RATE);
      else                                          r_hold <= w_hold_inc;
    end

    assign w_event[i]   = w_press || w_rep;
    assign btn_state[i] = r_state;
  end

  // Lowest-index pending channel wins; work out grant, clears and drops
  always_comb begin
    w_any = |r_pend;
    w_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) w_idx = DIR_W'(i);
    end
    w_load = !r_valid || move_ready;
    for (int i = 0; i < N_BTN; i++) begin
      w_clr[i] = w_load && w_any && (w_idx == DIR_W'(i));
    end
    // An event is lost only if its pending bit stays set through this edge
    w_drop     = w_event & r_pend & ~w_clr;
    w_pend_nxt = (r_pend & ~w_clr) | w_event;
    w_ndrop    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_ndrop = w_ndrop + 16'(w_drop[i]);
    end
    w_sum      = 16'(r_drop) + w_ndrop;
    w_drop_nxt = (w_sum > 16'd255) ? 8'hFF : w_sum[7:0];
  end

  // Pending bits, output register and saturating drop counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_dir   <= '0;
      r_drop  <= 8'h00;
    end else begin
      r_pend <= w_pend_nxt;
      r_drop <= w_drop_nxt;
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) r_dir <= w_idx;
      end
    end
  end

  assign move_valid = r_valid;
  assign move_dir   = r_dir;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_move_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_input_ctrl
//  Purpose  : Self-checking bench for move_input_ctrl (default parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_input_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] btn_in = 4'b0000;
  logic       repeat_en = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_state;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  typedef struct {
    logic [3:0] mask;
    int         exp_state_edge;
    int         exp_lat;
    int         exp_nev;
  } vec_t;

  move_input_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .btn_state  (btn_state),
    .drop_cnt   (drop_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each transfer pops the oldest expected direction
  always @(negedge Clk) begin
    if (Reset_n && move_valid && move_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_transfer", int'(move_dir), -1);
      end else begin
        check("transfer_dir", int'(move_dir), sb.pop_front());
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge Clk);
  endtask

  initial begin
    vec_t vecs[5];
    int   st_k, first_k, nval;
    int   got_t[$];
    int   exp_t[7] = '{7, 23, 27, 31, 35, 39, 43};

    vecs[0] = '{4'b0100, 6, 7, 1};
    vecs[1] = '{4'b1010, 6, 7, 2};
    vecs[2] = '{4'b0001, 6, 7, 1};
    vecs[3] = '{4'b1111, 6, 7, 4};
    vecs[4] = '{4'b1000, 6, 7, 1};

    // Reset state
    wait_cycles(3);
    #1;
    check("reset_valid", int'(move_valid), 0);
    check("reset_dir", int'(move_dir), 0);
    check("reset_state", int'(btn_state), 0);
    check("reset_drop", int'(drop_cnt), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    move_ready = 1'b1;
    wait_cycles(4);

    // Table-driven presses, repeat disabled, ready held high
    for (int v = 0; v < 5; v++) begin
      @(negedge Clk);
      for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) sb.push_back(i);
      btn_in = vecs[v].mask;
      st_k = 0; first_k = 0; nval = 0;
      for (int k = 1; k <= 30; k++) begin
        @(posedge Clk); #1;
        if (st_k == 0 && btn_state == vecs[v].mask) st_k = k;
        if (move_valid) begin
          if (first_k == 0) first_k = k;
          nval++;
        end
      end
      check($sformatf("vec%0d_state_edge", v), st_k, vecs[v].exp_state_edge);
      check($sformatf("vec%0d_latency", v), first_k, vecs[v].exp_lat);
      check($sformatf("vec%0d_nevents", v), nval, vecs[v].exp_nev);
      @(negedge Clk);
      btn_in = 4'b0000;
      wait_cycles(12);
      #1;
      check($sformatf("vec%0d_released", v), int'(btn_state), 0);
      check($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
    end
    check("drop_after_table", int'(drop_cnt), 0);

    // Bounce: toggles every 2 cycles for 12 cycles, then stays high
    @(negedge Clk);
    sb.push_back(0);
    nval = 0;
    for (int s = 0; s < 6; s++) begin
      btn_in = (s % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int k = 0; k < 2; k++) begin
        @(posedge Clk); #1;
        if (move_valid) nval++;
        @(negedge Clk);
      end
    end
    btn_in = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (move_valid) nval++;
    end
    check("bounce_nevents", nval, 1);
    check("bounce_drop", int'(drop_cnt), 0);
    @(negedge Clk);
    btn_in = 4'b0000;
    wait_cycles(12);

    // Auto-repeat on channel 1, held 40 cycles
    @(negedge Clk);
    repeat_en = 1'b1;
    for (int i = 0; i < 7; i++) sb.push_back(1);
    btn_in = 4'b0010;
    got_t.delete();
    for (int k = 1; k <= 60; k++) begin
      @(posedge Clk); #1;
      if (move_valid) got_t.push_back(k);
      if (k == 40) begin
        @(negedge Clk);
        btn_in = 4'b0000;
      end
    end
    check("repeat_nevents", got_t.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("repeat_t%0d", i), (i < got_t.size()) ? got_t[i] : -1, exp_t[i]);
    end
    check("repeat_sb_empty", sb.size(), 0);
    repeat_en = 1'b0;
    wait_cycles(5);

    // Backpressure: three presses of channel 0 with ready low
    @(negedge Clk);
    move_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (p < 2) sb.push_back(0);
      btn_in = 4'b0001;
      wait_cycles(10);
      @(negedge Clk);
      btn_in = 4'b0000;
      wait_cycles(10);
      #1;
      check($sformatf("bp_valid_%0d", p), int'(move_valid), 1);
      check($sformatf("bp_dir_%0d", p), int'(move_dir), 0);
      @(negedge Clk);
    end
    check("bp_drop", int'(drop_cnt), 1);
    move_ready = 1'b1;
    wait_cycles(5);
    #1;
    check("bp_drained_valid", int'(move_valid), 0);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_drop_kept", int'(drop_cnt), 1);

    // Reset mid-operation with a presented move and a pending bit
    @(negedge Clk);
    move_ready = 1'b0;
    btn_in = 4'b0101;
    wait_cycles(10);
    #1;
    check("pre_reset_valid", int'(move_valid), 1);
    check("pre_reset_dir", int'(move_dir), 0);
    #3;
    Reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_valid", int'(move_valid), 0);
    check("async_reset_dir", int'(move_dir), 0);
    check("async_reset_state", int'(btn_state), 0);
    check("async_reset_drop", int'(drop_cnt), 0);
    wait_cycles(2);
    @(negedge Clk);
    move_ready = 1'b1;
    sb.push_back(0);
    sb.push_back(2);
    Reset_n = 1'b1;
    first_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (first_k == 0 && move_valid) first_k = k;
    end
    check("post_reset_latency", first_k, 7);
    check("post_reset_sb_empty", sb.size(), 0);
    @(negedge Clk);
    btn_in = 4'b0000;
    wait_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
